// File: rtl/pattern_resp_pkg.sv
// Shared types and constants for the pattern-response MISR compaction stage.
package pattern_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Output count of the merged test_final netlist; bit 0 is ACVQN2_0_r_6.
  localparam int          RESP_W_DEF = 11;
  localparam logic [15:0] POLY_DEF   = 16'h1021;
  localparam logic [15:0] SEED_DEF   = 16'h0000;

endpackage

// File: rtl/pattern_resp_misr_core.sv
// Multiple-input signature register: loadable, enable-gated, one update per accepted sample.
module misr_core #(
  parameter int               SIG_W  = 16,
  parameter int               RESP_W = 11,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021
) (
  input  logic              clk,
  input  logic              load,
  input  logic [SIG_W-1:0]  load_val,
  input  logic              en,
  input  logic [RESP_W-1:0] data,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Shift left, fold POLY back in when the MSB leaves, then XOR the zero-extended sample.
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                  input logic [RESP_W-1:0] d);
    logic [SIG_W-1:0] fb;
    fb = s[SIG_W-1] ? POLY : '0;
    return (s << 1) ^ fb ^ SIG_W'(d);
  endfunction

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = load_val;
    end else if (en) begin
      sig_d = misr_next(sig_q, data);
    end
  end

  always_ff @(posedge clk) begin
    sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/pattern_resp_misr.sv
// Response compaction: folds test_final outputs into a MISR over a window and grades the result.
module pattern_resp_misr
  import pattern_resp_pkg::*;
#(
  parameter int               RESP_W  = RESP_W_DEF,
  parameter int               SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED    = SIG_W'(SEED_DEF),
  parameter int               CNT_W   = 16,
  parameter int               TIMEOUT = 64
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  window_len,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_in,
  input  logic [SIG_W-1:0]  expected_sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  sample_count
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   win_q, win_d;
  logic [SIG_W-1:0]   exp_q, exp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               tmo_q, tmo_d;
  logic               misr_load;
  logic               misr_en;
  logic [SIG_W-1:0]   sig;

  misr_core #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W),
    .POLY   (POLY)
  ) u_misr (
    .clk      (blif_clk_net),
    .load     (misr_load),
    .load_val (SEED),
    .en       (misr_en),
    .data     (resp_in),
    .sig      (sig)
  );

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    tmo_d     = tmo_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;

    if (abort) begin
      // Signature and count are left as they were so the aborted window can be inspected.
      state_d = IDLE;
      tmo_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            win_d     = window_len;
            exp_d     = expected_sig;
            cnt_d     = '0;
            idle_d    = '0;
            tmo_d     = 1'b0;
            misr_load = 1'b1;
            state_d   = (window_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (resp_valid) begin
            misr_en = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            idle_d  = '0;
            if (cnt_d == win_q) begin
              state_d = DONE;
            end
          end else begin
            idle_d = idle_q + 1'b1;
            if (idle_d == IDLE_W'(TIMEOUT)) begin
              state_d = DONE;
              tmo_d   = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (blif_reset_net) begin
      misr_load = 1'b1;
      misr_en   = 1'b0;
    end
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      tmo_q   <= tmo_d;
    end
  end

  // Window length and golden value are data only; they are always reloaded on start.
  always_ff @(posedge blif_clk_net) begin
    win_q <= win_d;
    exp_q <= exp_d;
  end

  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign timeout      = done && tmo_q;
  assign pass         = done && !tmo_q && (sig == exp_q);
  assign signature    = sig;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_pattern_resp_misr.sv
// Scoreboard bench for pattern_resp_misr: default-seed and 16'h8000-seed instances share stimulus.
module tb_pattern_resp_misr;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] window_len;
  logic        resp_valid;
  logic [10:0] resp_in;
  logic [15:0] expected_sig;

  logic        busy_a, done_a, pass_a, tmo_a;
  logic [15:0] sig_a, cnt_a;
  logic        busy_b, done_b, pass_b, tmo_b;
  logic [15:0] sig_b, cnt_b;

  always #5 clk = ~clk;

  pattern_resp_misr u_dut_a (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .start          (start),
    .abort          (abort),
    .window_len     (window_len),
    .resp_valid     (resp_valid),
    .resp_in        (resp_in),
    .expected_sig   (expected_sig),
    .busy           (busy_a),
    .done           (done_a),
    .pass           (pass_a),
    .timeout        (tmo_a),
    .signature      (sig_a),
    .sample_count   (cnt_a)
  );

  pattern_resp_misr #(.SEED(16'h8000)) u_dut_b (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .start          (start),
    .abort          (abort),
    .window_len     (window_len),
    .resp_valid     (resp_valid),
    .resp_in        (resp_in),
    .expected_sig   (expected_sig),
    .busy           (busy_b),
    .done           (done_b),
    .pass           (pass_b),
    .timeout        (tmo_b),
    .signature      (sig_b),
    .sample_count   (cnt_b)
  );

  typedef struct {
    logic [15:0] sig_a;
    logic [15:0] sig_b;
    logic [15:0] cnt;
    logic        pass_a;
    logic        pass_b;
    logic        tmo;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] samp[0:31];
  int          total = 0;
  int          bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s, input logic [10:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {5'b0, d};
  endfunction

  function automatic logic [15:0] model_sig(input logic [15:0] seed, input int n);
    logic [15:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = step(s, samp[i]);
    return s;
  endfunction

  task automatic check_reset(input string tag);
    check_val({tag, "_busy"},  32'(busy_a), 32'd0);
    check_val({tag, "_done"},  32'(done_a), 32'd0);
    check_val({tag, "_pass"},  32'(pass_a), 32'd0);
    check_val({tag, "_tmo"},   32'(tmo_a),  32'd0);
    check_val({tag, "_sig_a"}, 32'(sig_a),  32'h0000);
    check_val({tag, "_sig_b"}, 32'(sig_b),  32'h8000);
    check_val({tag, "_cnt"},   32'(cnt_a),  32'd0);
  endtask

  // Drives one window; nsamp < len leaves the window to end by idle timeout.
  task automatic do_window(input string tag, input int len, input logic [15:0] esig,
                           input int nsamp, input bit gap);
    exp_t e;
    exp_t g;
    int   nacc;
    int   n;
    nacc     = (nsamp < len) ? nsamp : len;
    e.sig_a  = model_sig(16'h0000, nacc);
    e.sig_b  = model_sig(16'h8000, nacc);
    e.cnt    = 16'(nacc);
    e.tmo    = (nsamp < len);
    e.pass_a = !e.tmo && (e.sig_a == esig);
    e.pass_b = !e.tmo && (e.sig_b == esig);
    e.lat    = e.tmo ? 64 : 0;
    exp_q.push_back(e);

    start = 1'b1; window_len = 16'(len); expected_sig = esig;
    @(posedge clk); #1;
    start = 1'b0; window_len = 16'($urandom); expected_sig = 16'($urandom);
    check_val({tag, "_busy_start"}, 32'(busy_a), 32'(len != 0));
    check_val({tag, "_done_start"}, 32'(done_a), 32'(len == 0));

    for (int i = 0; i < nacc; i++) begin
      resp_valid = 1'b1; resp_in = samp[i];
      @(posedge clk); #1;
      if (gap && i != nacc - 1) begin
        resp_valid = 1'b0; resp_in = 11'($urandom);
        @(posedge clk); #1;
      end
    end
    resp_valid = 1'b0;

    n = 0;
    while (!done_a && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    g = exp_q.pop_front();
    check_val({tag, "_done"},  32'(done_a), 32'd1);
    check_val({tag, "_lat"},   32'(n),      32'(g.lat));
    check_val({tag, "_busy"},  32'(busy_a), 32'd0);
    check_val({tag, "_sig_a"}, 32'(sig_a),  32'(g.sig_a));
    check_val({tag, "_sig_b"}, 32'(sig_b),  32'(g.sig_b));
    check_val({tag, "_cnt"},   32'(cnt_a),  32'(g.cnt));
    check_val({tag, "_pass_a"}, 32'(pass_a), 32'(g.pass_a));
    check_val({tag, "_pass_b"}, 32'(pass_b), 32'(g.pass_b));
    check_val({tag, "_tmo"},   32'(tmo_a),  32'(g.tmo));
  endtask

  initial begin
    logic [15:0] hold_sig;
    logic [15:0] hold_cnt;
    rst = 1'b1; start = 1'b0; abort = 1'b0; window_len = '0;
    resp_valid = 1'b0; resp_in = '0; expected_sig = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    samp[0] = 11'h001; samp[1] = 11'h000;
    do_window("win2_pass", 2, 16'h0002, 2, 1'b0);
    check_val("win2_sig_const", 32'(sig_a), 32'h0002);
    do_window("win2_fail", 2, 16'h0003, 2, 1'b0);

    samp[0] = 11'h000;
    do_window("tap", 1, 16'h1021, 1, 1'b0);
    check_val("tap_sig_const", 32'(sig_b), 32'h1021);

    do_window("zero", 0, 16'h0000, 0, 1'b0);

    samp[0] = 11'h5a5;
    do_window("timeout", 5, 16'h0000, 1, 1'b0);

    for (int i = 0; i < 12; i++) samp[i] = 11'($urandom);
    samp[3] = 11'h7ff;
    do_window("rand_gap", 12, model_sig(16'h0000, 12), 12, 1'b1);

    // Samples offered while DONE must not move the signature or count.
    hold_sig = sig_a; hold_cnt = cnt_a;
    resp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      resp_in = 11'($urandom);
      @(posedge clk); #1;
    end
    resp_valid = 1'b0;
    check_val("done_hold_sig",  32'(sig_a),  32'(hold_sig));
    check_val("done_hold_cnt",  32'(cnt_a),  32'(hold_cnt));
    check_val("done_hold_done", 32'(done_a), 32'd1);

    // Abort colliding with a valid sample: sample dropped, state back to IDLE.
    start = 1'b1; window_len = 16'd4; expected_sig = 16'h0000;
    @(posedge clk); #1;
    start = 1'b0;
    resp_valid = 1'b1; resp_in = 11'h005;
    @(posedge clk); #1;
    abort = 1'b1; resp_in = 11'h7ff;
    @(posedge clk); #1;
    abort = 1'b0; resp_valid = 1'b0;
    check_val("abort_busy", 32'(busy_a), 32'd0);
    check_val("abort_done", 32'(done_a), 32'd0);
    check_val("abort_pass", 32'(pass_a), 32'd0);
    check_val("abort_sig",  32'(sig_a),  32'h0005);
    check_val("abort_cnt",  32'(cnt_a),  32'd1);
    @(posedge clk); #1;
    check_val("abort_idle_done", 32'(done_a), 32'd0);

    // Reset in the middle of a window discards it.
    start = 1'b1; window_len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    resp_valid = 1'b1; resp_in = 11'h123;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; resp_valid = 1'b0;
    check_reset("midrst");

    samp[0] = 11'h3c3; samp[1] = 11'h0f0; samp[2] = 11'h001;
    do_window("post_rst", 3, model_sig(16'h0000, 3), 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_resp_misr.md
Name: pattern_resp_misr

Overview:
- Response-compaction stage directly downstream of the merged pattern netlist `test_final` (pattern_1_6).
- Consumes its 11 registered/combinational outputs each cycle and folds them into a multiple-input signature register (MISR) over a programmable window.
- Compares the final signature against an expected value and reports pass, fail or timeout.
- Used by the grammar-tool benches to check that merged graphs preserve their response sequence without storing full traces.

Parameters:
- RESP_W, 11, width of the response vector (`test_final` output count).
- SIG_W, 16, signature width; must be >= RESP_W.
- POLY, 16'h1021, MISR feedback polynomial (taps applied when the MSB shifts out).
- SEED, 16'h0000, signature value loaded at start.
- CNT_W, 16, width of the window and sample counters.
- TIMEOUT, 64, maximum consecutive idle cycles (resp_valid=0) tolerated in RUN.

Ports:
- blif_clk_net  in  1  sole clock; rising edge.
- blif_reset_net  in  1  synchronous, active-high reset.
- start  in  1  begin a compaction window; sampled in IDLE and DONE only.
- abort  in  1  return to IDLE immediately; no result reported.
- window_len  in  CNT_W  number of valid samples to compact; captured on start.
- resp_valid  in  1  resp_in is a valid sample this cycle.
- resp_in  in  RESP_W  response vector; bit order = `test_final` output order, ACVQN2_0_r_6 at bit 0.
- expected_sig  in  SIG_W  golden signature; captured on start.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until next start/abort.
- pass  out  1  valid when done; signature == expected and no timeout.
- timeout  out  1  valid when done; window ended by idle timeout.
- signature  out  SIG_W  current MISR value; final value frozen in DONE.
- sample_count  out  CNT_W  valid samples accepted in the current/last window.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, pass=0, timeout=0; signature=SEED; sample_count=0; idle counter=0.
- MISR update on each accepted sample: next = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_in).
- States:
  - IDLE: on start, go to RUN; load sig=SEED, count=0, idle=0; latch window_len and expected_sig. If the latched window_len==0, go straight to DONE instead, with signature=SEED.
  - RUN:
    - resp_valid=1: update MISR, count++, idle=0.
    - resp_valid=0: idle++.
    - When the accepted sample brings count to window_len, go to DONE on the next edge. done rises 1 cycle after the last sample.
    - When idle reaches TIMEOUT, go to DONE with timeout=1, pass=0.
  - DONE: done=1; pass=(signature==expected_latched) && !timeout. start restarts exactly as from IDLE; done drops the same edge RUN is entered.
- resp_valid is ignored outside RUN; signature and count do not change.
- start during RUN is ignored. window_len and expected_sig changes after start have no effect.
- abort has priority over start and over sample acceptance: next state IDLE, done/pass/timeout cleared, signature and count retain their last values.
- Reset has priority over everything; reset mid-window discards the window.
- Counter wrap: window_len up to 2^CNT_W-1; count never wraps because the window ends first.
- Simultaneous last sample and idle==TIMEOUT is impossible, since a valid sample clears idle; the last sample wins.

Decomposition:
- Shared package pattern_resp_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - default POLY/SEED constants;
  - RESP_W = 11 tied to the `test_final` port count.
- One sub-module misr_core (SIG_W, RESP_W, POLY): load/enable/data in, signature out; contains the update equation only.
- FSM, counters and compare live in the top.

Test Plan:
- Window of 2 with defaults: start with window_len=2, expected=16'h0002; samples 11'h001 then 11'h000 -> signature=16'h0002, done 1 cycle after 2nd sample, pass=1, sample_count=2.
- Same stimulus with expected=16'h0003 -> done=1, pass=0, timeout=0.
- Feedback tap: seed forced to 16'h8000 via param, 1 sample 11'h000 -> signature=16'h1021.
- Zero window: start with window_len=0 -> DONE next cycle, signature=SEED, sample_count=0.
- Timeout: start with window_len=5, 1 valid sample, then resp_valid low for 64 cycles -> done=1, timeout=1, pass=0, sample_count=1.
- Control priority:
  - abort asserted together with a valid sample in RUN -> IDLE next cycle, sample not accumulated, done=0.
  - reset mid-window -> all outputs at reset values.
